bias_bank_pingpong: RTL and testbench
=====================================

Name: bias_bank_pingpong

Overview:
- Runtime-loadable, double-buffered bias bank feeding the per-channel bias adders behind the adder trees.
- Generalises the fixed per-layer constant bias modules:
  - Biases for every output-channel group of a layer are streamed in once.
  - Loading the next layer happens in the background while the current layer runs.
  - The active group is presented as one wide word of N_adder_tree lanes.
- Sits between the weight/bias fetch path (stream in) and the accumulator/bias-add stage (q out).

Parameters:
- N_adder_tree, 16: lanes per group; width of q is N_adder_tree*DATA_W.
- DATA_W, 18: bias word width, two's complement, same fixed-point format as the accumulators.
- N_GROUPS, 4: output-channel groups per layer. Bank depth is N_adder_tree*N_GROUPS words. Must be >= 1.
- GRP_W, $clog2(N_GROUPS) (min 1): width of grp_idx.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  load stream word valid.
- in_ready  out  1  load stream ready.
- in_data  in  DATA_W  bias word; lane-major within group, group-major overall.
- swap  in  1  single-cycle request to make the loaded shadow bank active.
- next_grp  in  1  advance active group index.
- shadow_full  out  1  shadow bank holds a complete layer.
- active_valid  out  1  active bank holds valid biases.
- grp_idx  out  GRP_W  current active group.
- q  out  N_adder_tree*DATA_W  biases of current group; lane i on q[DATA_W*(i+1)-1:DATA_W*i].
- q_valid  out  1  q is valid.

Behaviour:
- Storage and reset:
  - Two banks, each N_adder_tree*N_GROUPS x DATA_W. bank_sel picks the active bank; loads go to !bank_sel.
  - On rst: bank_sel=0, wr_ptr=0, shadow_full=0, active_valid=0, grp_idx=0, q=0, q_valid=0.
  - Bank contents are not reset.
  - rst mid-load discards the partial load.
- Load:
  - in_ready = !shadow_full (combinational from the register).
  - Accept when in_valid && in_ready: shadow[wr_ptr] <= in_data, wr_ptr++.
  - Accepting word N_adder_tree*N_GROUPS-1 sets shadow_full=1 and wr_ptr=0 on the same edge.
  - No accepts while shadow_full=1; in_data is ignored.
- Swap:
  - swap && shadow_full: bank_sel toggles, shadow_full<=0, active_valid<=1, grp_idx<=0.
  - swap while !shadow_full is ignored. This includes the cycle the last word is accepted, where shadow_full is still 0.
  - Loading into the new shadow may start the cycle after the swap.
- Group advance:
  - next_grp && active_valid: grp_idx <= (grp_idx==N_GROUPS-1) ? 0 : grp_idx+1 (wrap).
  - Ignored when !active_valid.
  - swap (accepted) and next_grp in the same cycle: swap wins, grp_idx=0.
  - N_GROUPS=1: grp_idx stays 0.
- Output:
  - q is registered: q <= active[grp_idx*N_adder_tree + i] for each lane i.
  - One-cycle latency from any grp_idx or bank_sel change to q.
  - q_valid <= active_valid.
  - q is forced to 0 while active_valid=0.
  - Values pass through unmodified; no sign extension or rounding.
- Loading the shadow bank never disturbs q.

Test Plan (N_adder_tree=4, DATA_W=18, N_GROUPS=2 unless noted):
1. Reset then idle 5 cycles -> in_ready=1, shadow_full=0, q=0, q_valid=0, grp_idx=0.
2. Stream words 0x00001..0x00008 with in_valid held high, then swap -> shadow_full=1 after the 8th accept, in_ready=0. The cycle after the swap q_valid=1 and q lanes 0..3 = 1,2,3,4. After next_grp, q lanes = 5,6,7,8 one cycle later. A second next_grp wraps back to 1,2,3,4.
3. Negative values: load 0x3FFFF, 0x20000, 0x1FFFF, 0x00000 in group 0 -> q lanes match bit-exactly.
4. Load layer B (0x10..0x17) with random in_valid gaps while layer A is active and next_grp toggles -> q shows only layer A values until swap. After swap, q = 0x10..0x13 and grp_idx=0.
5. Edge cases:
   - swap asserted on the same cycle as the last accept -> ignored, shadow_full=1 next cycle, active bank unchanged.
   - swap and next_grp in the same cycle -> grp_idx=0.
   - 9th word offered while full -> not accepted.
6. rst after 3 of 8 words -> wr_ptr restarts. A full reload of 8 words then swap gives correct q; q_valid=0 until that swap.

Source files
------------

// File: rtl/bias_bank_pingpong.sv
// Double-buffered bias bank: a layer of biases streams into the shadow bank while the
// active bank drives one output-channel group per cycle onto a wide registered q word.
module bias_bank_pingpong #(
    parameter int N_adder_tree = 16,
    parameter int DATA_W       = 18,
    parameter int N_GROUPS     = 4,
    parameter int GRP_W        = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_W-1:0]                in_data,
    input  logic                             swap,
    input  logic                             next_grp,
    output logic                             shadow_full,
    output logic                             active_valid,
    output logic [GRP_W-1:0]                 grp_idx,
    output logic [N_adder_tree*DATA_W-1:0]   q,
    output logic                             q_valid
);

    localparam int DEPTH = N_adder_tree * N_GROUPS;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0]              bank0 [0:DEPTH-1];
    logic [DATA_W-1:0]              bank1 [0:DEPTH-1];
    logic                           bankSel;
    logic [PTR_W-1:0]               wrPtr;
    logic [PTR_W-1:0]               grpBase;
    logic [N_adder_tree*DATA_W-1:0] qNext;
    logic                           accept;
    logic                           lastWord;
    logic                           swapTake;

    assign in_ready = !shadow_full;
    assign accept   = in_valid && in_ready;
    assign lastWord = (wrPtr == PTR_W'(DEPTH - 1));
    assign swapTake = swap && shadow_full;

    // Loads always target the bank that is not currently selected for output.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (bankSel)
                bank0[wrPtr] <= in_data;
            else
                bank1[wrPtr] <= in_data;
        end
    end

    // Gather the lanes of the current group from the active bank, zeroed until a layer is live.
    always_comb begin
        qNext   = '0;
        grpBase = PTR_W'(grp_idx) * PTR_W'(N_adder_tree);
        if (active_valid) begin
            for (int i = 0; i < N_adder_tree; i++) begin
                qNext[i*DATA_W +: DATA_W] = bankSel ? bank1[grpBase + PTR_W'(i)]
                                                    : bank0[grpBase + PTR_W'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bankSel      <= 1'b0;
            wrPtr        <= '0;
            shadow_full  <= 1'b0;
            active_valid <= 1'b0;
            grp_idx      <= '0;
            q            <= '0;
            q_valid      <= 1'b0;
        end else begin
            if (accept) begin
                if (lastWord) begin
                    wrPtr       <= '0;
                    shadow_full <= 1'b1;
                end else begin
                    wrPtr <= wrPtr + 1'b1;
                end
            end

            // An accepted swap restarts at group 0 and overrides a simultaneous group advance.
            if (swapTake) begin
                bankSel      <= !bankSel;
                shadow_full  <= 1'b0;
                active_valid <= 1'b1;
                grp_idx      <= '0;
            end else if (next_grp && active_valid) begin
                if (grp_idx == GRP_W'(N_GROUPS - 1))
                    grp_idx <= '0;
                else
                    grp_idx <= grp_idx + 1'b1;
            end

            q       <= qNext;
            q_valid <= active_valid;
        end
    end

endmodule

// File: tb/tb_bias_bank_pingpong.sv
// Directed bench for bias_bank_pingpong with 4 lanes x 18 bits and 2 groups; inputs change
// on the falling edge and outputs are checked on the following falling edge.
module tb_bias_bank_pingpong;

    localparam int NL = 4;
    localparam int DW = 18;
    localparam int NG = 2;
    localparam int QW = NL * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          swap;
    logic          next_grp;
    logic          shadow_full;
    logic          active_valid;
    logic [0:0]    grp_idx;
    logic [QW-1:0] q;
    logic          q_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bias_bank_pingpong #(
        .N_adder_tree(NL),
        .DATA_W      (DW),
        .N_GROUPS    (NG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .swap        (swap),
        .next_grp    (next_grp),
        .shadow_full (shadow_full),
        .active_valid(active_valid),
        .grp_idx     (grp_idx),
        .q           (q),
        .q_valid     (q_valid)
    );

    function automatic logic [QW-1:0] lanes(input logic [DW-1:0] l0, input logic [DW-1:0] l1,
                                            input logic [DW-1:0] l2, input logic [DW-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic sw,
                                 input logic ng);
        in_valid = v;
        in_data  = d;
        swap     = sw;
        next_grp = ng;
        @(negedge clk);
        in_valid = 1'b0;
        swap     = 1'b0;
        next_grp = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [QW-1:0] observed,
                               input logic [QW-1:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    logic [QW-1:0] layerA [0:1];
    logic [11:0]   gapPat;
    logic          v;
    int            nB;
    int            g;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        swap     = 1'b0;
        next_grp = 1'b0;
        layerA[0] = lanes(18'h3FFFF, 18'h20000, 18'h1FFFF, 18'h00000);
        layerA[1] = lanes(18'h00021, 18'h00022, 18'h00023, 18'h00024);
        gapPat    = 12'b1110_1100_1101;

        // Reset and idle
        @(negedge clk);
        applyStimulus(0, '0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(0, '0, 0, 0);
        checkOutput("rst_in_ready", QW'(in_ready), QW'(1));
        checkOutput("rst_shadow_full", QW'(shadow_full), QW'(0));
        checkOutput("rst_q", q, '0);
        checkOutput("rst_q_valid", QW'(q_valid), QW'(0));
        checkOutput("rst_grp_idx", QW'(grp_idx), QW'(0));

        // First layer, back-to-back words
        for (int k = 1; k <= 7; k++) applyStimulus(1, DW'(k), 0, 0);
        checkOutput("load7_not_full", QW'(shadow_full), QW'(0));
        applyStimulus(1, 18'h00008, 0, 0);
        checkOutput("load8_full", QW'(shadow_full), QW'(1));
        checkOutput("load8_in_ready", QW'(in_ready), QW'(0));
        checkOutput("load_q_quiet", q, '0);
        applyStimulus(0, '0, 1, 0);
        checkOutput("swap_edge_q_valid", QW'(q_valid), QW'(0));
        checkOutput("swap_clears_full", QW'(shadow_full), QW'(0));
        applyStimulus(0, '0, 0, 0);
        checkOutput("swap1_q_valid", QW'(q_valid), QW'(1));
        checkOutput("swap1_q_g0", q, lanes(1, 2, 3, 4));
        applyStimulus(0, '0, 0, 1);
        checkOutput("next1_grp_idx", QW'(grp_idx), QW'(1));
        checkOutput("next1_q_latency", q, lanes(1, 2, 3, 4));
        applyStimulus(0, '0, 0, 0);
        checkOutput("next1_q_g1", q, lanes(5, 6, 7, 8));
        applyStimulus(0, '0, 0, 1);
        applyStimulus(0, '0, 0, 0);
        checkOutput("wrap_grp_idx", QW'(grp_idx), QW'(0));
        checkOutput("wrap_q_g0", q, lanes(1, 2, 3, 4));

        // Layer A with negative / extreme values in group 0
        applyStimulus(1, 18'h3FFFF, 0, 0);
        applyStimulus(1, 18'h20000, 0, 0);
        applyStimulus(1, 18'h1FFFF, 0, 0);
        applyStimulus(1, 18'h00000, 0, 0);
        for (int k = 1; k <= 4; k++) applyStimulus(1, DW'(32 + k), 0, 0);
        checkOutput("loadA_q_holds_old", q, lanes(1, 2, 3, 4));
        applyStimulus(0, '0, 1, 0);
        applyStimulus(0, '0, 0, 0);
        checkOutput("neg_q_g0", q, layerA[0]);

        // Layer B streamed with gaps while layer A is live and groups advance
        nB = 0;
        g  = 0;
        for (int i = 0; i < 12; i++) begin
            v = gapPat[i];
            applyStimulus(v, v ? DW'(16 + nB) : 18'h3ABCD, 0, i[0]);
            checkOutput("bg_load_q_layerA", q, layerA[g]);
            if (v) nB++;
            if (i[0]) g = 1 - g;
        end
        checkOutput("bg_load_full", QW'(shadow_full), QW'(1));
        applyStimulus(0, '0, 1, 0);
        checkOutput("swapB_grp_idx", QW'(grp_idx), QW'(0));
        applyStimulus(0, '0, 0, 0);
        checkOutput("swapB_q_g0", q, lanes(18'h10, 18'h11, 18'h12, 18'h13));

        // Swap coinciding with the last accept is ignored
        applyStimulus(0, '0, 0, 1);
        for (int k = 0; k < 7; k++) applyStimulus(1, DW'(48 + k), 0, 0);
        applyStimulus(1, 18'h00037, 1, 0);
        checkOutput("late_swap_full", QW'(shadow_full), QW'(1));
        checkOutput("late_swap_grp_idx", QW'(grp_idx), QW'(1));
        applyStimulus(0, '0, 0, 0);
        checkOutput("late_swap_q_same_bank", q, lanes(18'h14, 18'h15, 18'h16, 18'h17));

        // Word offered while full must be dropped
        applyStimulus(1, 18'h0003F, 0, 0);
        checkOutput("full_in_ready", QW'(in_ready), QW'(0));
        checkOutput("full_still_full", QW'(shadow_full), QW'(1));

        // Swap and next_grp together: swap wins
        applyStimulus(0, '0, 1, 1);
        checkOutput("swap_next_grp_idx", QW'(grp_idx), QW'(0));
        applyStimulus(0, '0, 0, 0);
        checkOutput("swap_next_q_g0", q, lanes(18'h30, 18'h31, 18'h32, 18'h33));

        // Reset part-way through a load, then a full reload
        applyStimulus(1, 18'h00040, 0, 0);
        applyStimulus(1, 18'h00041, 0, 0);
        applyStimulus(1, 18'h00042, 0, 0);
        rst = 1'b1;
        applyStimulus(0, '0, 0, 0);
        rst = 1'b0;
        checkOutput("midrst_q", q, '0);
        checkOutput("midrst_q_valid", QW'(q_valid), QW'(0));
        checkOutput("midrst_in_ready", QW'(in_ready), QW'(1));
        for (int k = 0; k < 8; k++) applyStimulus(1, DW'(80 + k), 0, 0);
        checkOutput("reload_q_valid_low", QW'(q_valid), QW'(0));
        checkOutput("reload_full", QW'(shadow_full), QW'(1));
        applyStimulus(0, '0, 1, 0);
        applyStimulus(0, '0, 0, 0);
        checkOutput("reload_q_valid", QW'(q_valid), QW'(1));
        checkOutput("reload_q_g0", q, lanes(18'h50, 18'h51, 18'h52, 18'h53));
        applyStimulus(0, '0, 0, 1);
        applyStimulus(0, '0, 0, 0);
        checkOutput("reload_q_g1", q, lanes(18'h54, 18'h55, 18'h56, 18'h57));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
